// File: rtl/fen_stream_decoder.sv
// fen_stream_decoder: parses one ASCII FEN record per sop..eop frame into a registered square stream
// followed by header fields and an error flag. Optional FEN_STRICT_EN adds rank/'/'-count/ep-rank checks.
module fen_stream_decoder #(
  parameter int COUNT_W   = 16,
  parameter int IDX_ORDER = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               o_sq_valid,
  output logic [5:0]         o_sq_idx,
  output logic [3:0]         o_pdata,
  output logic               o_valid,
  output logic               o_error,
  output logic               o_turn,
  output logic [3:0]         o_castle,
  output logic               o_ep_valid,
  output logic [2:0]         o_ep,
  output logic [COUNT_W-1:0] o_hmcount,
  output logic [COUNT_W-1:0] o_fmcount
);
  typedef enum logic [3:0] {
    S_IDLE, S_BOARD, S_EXPAND, S_TURN, S_CASTLE, S_EP, S_EP_RANK, S_HM, S_FM, S_ERR
  } state_t;

  localparam logic [5:0] IDX_XOR = (IDX_ORDER != 0) ? 6'o70 : 6'o00;

  state_t               state_q, state_d, es;
  logic [6:0]           cnt_q, cnt_d;
  logic [2:0]           rem_q, rem_d;
  logic                 any_q, any_d, dash_q, dash_d;
  logic                 sq_valid_q, sq_valid_d, valid_q, valid_d, error_q, error_d;
  logic [5:0]           sq_idx_q, sq_idx_d;
  logic [3:0]           pdata_q, pdata_d, castle_q, castle_d;
  logic                 turn_q, turn_d, epv_q, epv_d;
  logic [2:0]           ep_q, ep_d;
  logic [COUNT_W-1:0]   hm_q, hm_d, fm_q, fm_d;
  logic                 bad, dig, sqdig, ep_ok;
  logic [3:0]           pc, cb, step;
`ifdef FEN_STRICT_EN
  logic [3:0]           rank_q, rank_d;
  logic [2:0]           slash_q, slash_d;
`endif

  function automatic logic [3:0] piece_code(input logic [7:0] c);
    case (c)
      "P": piece_code = 4'h1;  "N": piece_code = 4'h2;  "B": piece_code = 4'h3;
      "R": piece_code = 4'h4;  "Q": piece_code = 4'h5;  "K": piece_code = 4'h6;
      "p": piece_code = 4'h9;  "n": piece_code = 4'hA;  "b": piece_code = 4'hB;
      "r": piece_code = 4'hC;  "q": piece_code = 4'hD;  "k": piece_code = 4'hE;
      default: piece_code = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] castle_bit(input logic [7:0] c);
    case (c)
      "K": castle_bit = 4'b1000;  "Q": castle_bit = 4'b0100;
      "k": castle_bit = 4'b0010;  "q": castle_bit = 4'b0001;
      default: castle_bit = 4'b0000;
    endcase
  endfunction

  // acc*10 + d computed 4 bits wider so overflow is visible, then clamped at all-ones
  function automatic logic [COUNT_W-1:0] dec_acc(input logic [COUNT_W-1:0] acc, input logic [3:0] d);
    logic [COUNT_W+3:0] w;
    w = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{COUNT_W{1'b0}}, d};
    if (w > {4'b0000, {COUNT_W{1'b1}}}) dec_acc = '1;
    else                                dec_acc = w[COUNT_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  rem_d = rem_q;  any_d = any_q;  dash_d = dash_q;
    sq_valid_d = 1'b0;  sq_idx_d = sq_idx_q;  pdata_d = pdata_q;
    valid_d = 1'b0;  error_d = error_q;  turn_d = turn_q;  castle_d = castle_q;
    epv_d = epv_q;  ep_d = ep_q;  hm_d = hm_q;  fm_d = fm_q;
`ifdef FEN_STRICT_EN
    rank_d = rank_q;  slash_d = slash_q;
`endif
    es    = state_q;
    bad   = 1'b0;
    pc    = piece_code(in_data);
    cb    = castle_bit(in_data);
    dig   = (in_data >= 8'h30) && (in_data <= 8'h39);
    sqdig = (in_data >= 8'h31) && (in_data <= 8'h38);
    step  = (pc != 4'h0) ? 4'd1 : in_data[3:0];
`ifdef FEN_STRICT_EN
    ep_okay_strict: ep_ok = turn_q ? (in_data == "3") : (in_data == "6");
`else
    ep_ok = sqdig;
`endif

    if (state_q == S_EXPAND) begin
      sq_valid_d = 1'b1;
      sq_idx_d   = cnt_q[5:0] ^ IDX_XOR;
      pdata_d    = '0;
      cnt_d      = cnt_q + 7'd1;
      rem_d      = rem_q - 3'd1;
`ifdef FEN_STRICT_EN
      rank_d     = rank_q + 4'd1;
`endif
      if (rem_q == 3'd1) state_d = S_BOARD;
    end else if (in_valid) begin
      // sop restarts the record from any state; the same byte is parsed as the first board byte
      if (in_sop) begin
        es = S_BOARD;  state_d = S_BOARD;  cnt_d = '0;  any_d = 1'b0;  dash_d = 1'b0;
        turn_d = 1'b0;  castle_d = '0;  epv_d = 1'b0;  ep_d = '0;  hm_d = '0;  fm_d = '0;
`ifdef FEN_STRICT_EN
        rank_d = '0;  slash_d = '0;
`endif
      end
      case (es)
        S_BOARD: begin
          if (pc != 4'h0 || sqdig) begin
            if (cnt_d + {3'b000, step} > 7'd64) bad = 1'b1;
`ifdef FEN_STRICT_EN
            if ({1'b0, rank_d} + {1'b0, step} > 5'd8) bad = 1'b1;
            rank_d = rank_d + 4'd1;
`endif
            sq_valid_d = 1'b1;
            sq_idx_d   = cnt_d[5:0] ^ IDX_XOR;
            pdata_d    = pc;
            cnt_d      = cnt_d + 7'd1;
            rem_d      = 3'(step - 4'd1);
            if (step > 4'd1) state_d = S_EXPAND;
          end else if (in_data == "/") begin
`ifdef FEN_STRICT_EN
            if (rank_d != 4'd8 || slash_d == 3'd7) bad = 1'b1;
            slash_d = slash_d + 3'd1;
            rank_d  = '0;
`endif
          end else if (in_data == " ") begin
            if (cnt_d != 7'd64) bad = 1'b1;
`ifdef FEN_STRICT_EN
            if (rank_d != 4'd8 || slash_d != 3'd7) bad = 1'b1;
`endif
            state_d = S_TURN;
            any_d   = 1'b0;
          end else bad = 1'b1;
        end
        S_TURN: begin
          if (!any_q && (in_data == "w" || in_data == "b")) begin
            turn_d = (in_data == "b");
            any_d  = 1'b1;
          end else if (any_q && in_data == " ") begin
            state_d = S_CASTLE;
            any_d   = 1'b0;
          end else bad = 1'b1;
        end
        S_CASTLE: begin
          if (cb != 4'h0 && !dash_q && (castle_q & cb) == 4'h0) begin
            castle_d = castle_q | cb;
            any_d    = 1'b1;
          end else if (in_data == "-" && !any_q) begin
            any_d  = 1'b1;
            dash_d = 1'b1;
          end else if (in_data == " " && any_q) begin
            state_d = S_EP;
            any_d   = 1'b0;
            dash_d  = 1'b0;
          end else bad = 1'b1;
        end
        S_EP: begin
          if (!any_q && in_data == "-") any_d = 1'b1;
          else if (!any_q && in_data >= "a" && in_data <= "h") begin
            ep_d    = in_data[2:0] - 3'd1;
            state_d = S_EP_RANK;
          end else if (any_q && in_data == " ") begin
            state_d = S_HM;
            any_d   = 1'b0;
          end else bad = 1'b1;
        end
        S_EP_RANK: begin
          if (ep_ok) begin
            epv_d   = 1'b1;
            any_d   = 1'b1;
            state_d = S_EP;
          end else bad = 1'b1;
        end
        S_HM: begin
          if (dig) begin
            hm_d  = dec_acc(hm_q, in_data[3:0]);
            any_d = 1'b1;
          end else if (in_data == " " && any_q) begin
            state_d = S_FM;
            any_d   = 1'b0;
          end else bad = 1'b1;
        end
        S_FM: begin
          if (dig) fm_d = dec_acc(fm_q, in_data[3:0]);
          else     bad  = 1'b1;
        end
        default: ;
      endcase

      // eop closes the record; it is only clean when it carries a fullmove digit
      if (es != S_IDLE && in_eop) begin
        sq_valid_d = 1'b0;
        state_d    = S_IDLE;
        valid_d    = 1'b1;
        error_d    = !(es == S_FM && dig);
      end else if (bad) begin
        sq_valid_d = 1'b0;
        state_d    = S_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  cnt_q <= '0;  rem_q <= '0;  any_q <= 1'b0;  dash_q <= 1'b0;
      sq_valid_q <= 1'b0;  sq_idx_q <= '0;  pdata_q <= '0;  valid_q <= 1'b0;  error_q <= 1'b0;
      turn_q <= 1'b0;  castle_q <= '0;  epv_q <= 1'b0;  ep_q <= '0;  hm_q <= '0;  fm_q <= '0;
`ifdef FEN_STRICT_EN
      rank_q <= '0;  slash_q <= '0;
`endif
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  rem_q <= rem_d;  any_q <= any_d;  dash_q <= dash_d;
      sq_valid_q <= sq_valid_d;  sq_idx_q <= sq_idx_d;  pdata_q <= pdata_d;
      valid_q <= valid_d;  error_q <= error_d;
      turn_q <= turn_d;  castle_q <= castle_d;  epv_q <= epv_d;  ep_q <= ep_d;
      hm_q <= hm_d;  fm_q <= fm_d;
`ifdef FEN_STRICT_EN
      rank_q <= rank_d;  slash_q <= slash_d;
`endif
    end
  end

  assign in_ready   = (state_q != S_EXPAND);
  assign o_sq_valid = sq_valid_q;
  assign o_sq_idx   = sq_idx_q;
  assign o_pdata    = pdata_q;
  assign o_valid    = valid_q;
  assign o_error    = error_q;
  assign o_turn     = turn_q;
  assign o_castle   = castle_q;
  assign o_ep_valid = epv_q;
  assign o_ep       = ep_q;
  assign o_hmcount  = hm_q;
  assign o_fmcount  = fm_q;
endmodule
